uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 14 +
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_rx.sv | 119 +++++++++++
 tb/tb_uart_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM state type and frame constants.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DATA_BITS = 8;
    localparam int IDX_W     = $clog2(DATA_BITS);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous line; both flops reset high (idle).
// Latency: 2 clk. Backpressure: none.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of the synchronized line, one-cycle rx_valid/frame_err pulses.
// Latency: pulse registered HALF_BIT + 9*CLKS_PER_BIT edges after the start-detect edge (detect is 3 edges after rx falls).
// Backpressure: none; pulses are fire-and-forget and rx_data holds until the next good frame.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLOCK_FREQ = 12000000,
    parameter int BAUD       = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic                 w_start;
    logic                 r_rx_prev;
    rx_state_t            r_state,     w_state_nxt;
    logic [CNT_W-1:0]     r_cnt,       w_cnt_nxt;
    logic [IDX_W-1:0]     r_idx,       w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift,     w_shift_nxt;
    logic [DATA_BITS-1:0] r_rx_data,   w_rx_data_nxt;
    logic                 r_rx_valid,  w_rx_valid_nxt;
    logic                 r_frame_err, w_frame_err_nxt;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    // r_rx_prev tracks the line in every state, so a break must rise before a fall counts again.
    assign w_start = r_rx_prev & ~w_rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_prev   <= 1'b1;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_prev   <= w_rx_s;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + 1'b1;
        w_idx_nxt       = r_idx;
        w_shift_nxt     = r_shift;
        w_rx_data_nxt   = r_rx_data;
        w_rx_valid_nxt  = 1'b0;
        w_frame_err_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_start) w_state_nxt = START;
            end
            START: begin
                // Line back high at mid start bit: treat as a glitch.
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = w_rx_s;
                    w_idx_nxt          = r_idx + 1'b1;
                    if (r_idx == IDX_LAST) w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                    if (w_rx_s) begin
                        w_rx_data_nxt  = r_shift;
                        w_rx_valid_nxt = 1'b1;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven bit by bit, outputs checked every cycle against a
// schedule of expected pulses derived from frame timing, plus literal checks per scenario.
module tb_uart_rx;

    localparam int CPB      = 16;
    localparam int HALF     = CPB / 2;
    localparam int SYNC_LAT = 3;                         // two sync flops plus the detect edge
    localparam int LAT      = SYNC_LAT + HALF + 9 * CPB; // 155 edges from driving the start bit

    typedef struct {
        int         st;
        int         en;
        int         kind;   // 0 good frame, 1 framing error, 2 rejected glitch
        logic [7:0] d;
    } ev_t;

    typedef struct {
        int         c;
        logic [7:0] d;
    } got_t;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         ferr_cnt = 0;
    int         last_d = 0;
    logic [7:0] exp_data = 8'h00;
    ev_t        evq[$];
    got_t       got_q[$];

    uart_rx #(.CLOCK_FREQ(1600), .BAUD(100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Outputs after edge e: busy inside [st, en), pulse exactly at en.
    always @(negedge clk) begin : cmp_blk
        bit eb;
        bit ev;
        bit ef;
        eb = 1'b0;
        ev = 1'b0;
        ef = 1'b0;
        if (evq.size() > 0) begin
            if (cyc >= evq[0].st && cyc < evq[0].en) begin
                eb = 1'b1;
            end else if (cyc == evq[0].en) begin
                ev = (evq[0].kind == 0);
                ef = (evq[0].kind == 1);
                if (ev) exp_data = evq[0].d;
                void'(evq.pop_front());
            end
        end
        chk("busy", {31'b0, busy}, {31'b0, eb});
        chk("rx_valid", {31'b0, rx_valid}, {31'b0, ev});
        chk("frame_err", {31'b0, frame_err}, {31'b0, ef});
        chk("rx_data", {24'b0, rx_data}, {24'b0, exp_data});
        if (rx_valid === 1'b1) got_q.push_back('{c: cyc, d: rx_data});
        if (frame_err === 1'b1) ferr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int d, input int kind, input logic [7:0] b);
        ev_t e;
        e.st   = d + SYNC_LAT;
        e.en   = (kind == 2) ? d + SYNC_LAT + HALF : d + LAT;
        e.kind = kind;
        e.d    = b;
        evq.push_back(e);
    endtask

    // Leaves the stop level on the line; the caller decides what follows.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        tick();
        rx     = 1'b0;
        last_d = cyc;
        push_ev(cyc, stop_ok ? 0 : 1, b);
        repeat (CPB - 1) tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            rx = b[k];
            repeat (CPB - 1) tick();
        end
        tick();
        rx = stop_ok;
        repeat (CPB - 1) tick();
    endtask

    initial begin
        logic [7:0] b;
        bit         ok;
        int         gap;
        bit         released;

        rx    = 1'b1;
        rst_n = 1'b0;
        #2;
        chk("init_rx_data", {24'b0, rx_data}, 32'h0);
        chk("init_rx_valid", {31'b0, rx_valid}, 32'h0);
        chk("init_busy", {31'b0, busy}, 32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        // Single good frame, with latency pinned to 8 + 9*16 + 3.
        got_q.delete();
        ferr_cnt = 0;
        send_frame(8'hA5, 1'b1);
        repeat (20) tick();
        chk("a5_count", got_q.size(), 1);
        if (got_q.size() >= 1) begin
            chk("a5_data", {24'b0, got_q[0].d}, 32'hA5);
            chk("a5_latency", got_q[0].c - last_d, 155);
        end
        chk("a5_ferr", ferr_cnt, 0);
        chk("a5_busy_after", {31'b0, busy}, 32'h0);

        // Back-to-back frames with a single stop bit.
        got_q.delete();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (20) tick();
        chk("b2b_count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            chk("b2b_data0", {24'b0, got_q[0].d}, 32'h00);
            chk("b2b_data1", {24'b0, got_q[1].d}, 32'hFF);
            chk("b2b_spacing", got_q[1].c - got_q[0].c, 160);
        end

        // Four-clock glitch on the idle line.
        got_q.delete();
        ferr_cnt = 0;
        tick();
        rx = 1'b0;
        push_ev(cyc, 2, 8'h00);
        repeat (3) tick();
        tick();
        rx = 1'b1;
        released = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy === 1'b0) begin
                released = 1'b1;
                break;
            end
        end
        chk("glitch_busy_released", {31'b0, released}, 32'h1);
        repeat (20) tick();
        chk("glitch_no_valid", got_q.size(), 0);
        chk("glitch_no_ferr", ferr_cnt, 0);

        // Bad stop bit followed by a held-low line (break).
        got_q.delete();
        ferr_cnt = 0;
        send_frame(8'h3C, 1'b0);
        repeat (40) tick();
        chk("brk_ferr", ferr_cnt, 1);
        chk("brk_no_valid", got_q.size(), 0);
        chk("brk_data_held", {24'b0, rx_data}, 32'hFF);
        chk("brk_idle", {31'b0, busy}, 32'h0);
        tick();
        rx = 1'b1;
        repeat (5) tick();

        // Random frames, gaps down to zero, occasional bad stop bits.
        for (int n = 0; n < 24; n++) begin
            b   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 5) != 0);
            gap = $urandom_range(0, 12);
            send_frame(b, ok);
            if (!ok) begin
                tick();
                rx = 1'b1;
                gap = gap + 1;
            end
            repeat (gap) tick();
        end
        repeat (10) tick();

        // Reset in the middle of data bit 3, then a clean frame.
        b = 8'hC3;
        tick();
        rx = 1'b0;
        push_ev(cyc, 0, b);
        repeat (CPB - 1) tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            rx = b[k];
            repeat (CPB - 1) tick();
        end
        tick();
        rx = b[3];
        repeat (7) tick();
        rst_n = 1'b0;
        evq.delete();
        exp_data = 8'h00;
        got_q.delete();
        ferr_cnt = 0;
        #1;
        chk("rst_rx_data", {24'b0, rx_data}, 32'h0);
        chk("rst_rx_valid", {31'b0, rx_valid}, 32'h0);
        chk("rst_frame_err", {31'b0, frame_err}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        rx = 1'b1;
        repeat (10) tick();
        chk("rst_hold_busy", {31'b0, busy}, 32'h0);
        chk("rst_hold_data", {24'b0, rx_data}, 32'h0);
        rst_n = 1'b1;
        repeat (10) tick();
        send_frame(8'h5A, 1'b1);
        repeat (20) tick();
        chk("rst_after_count", got_q.size(), 1);
        if (got_q.size() >= 1) chk("rst_after_data", {24'b0, got_q[0].d}, 32'h5A);
        chk("rst_after_ferr", ferr_cnt, 0);
        chk("evq_drained", evq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
